// File: rtl/mult_booth_seq_pkg.sv
// rtl/mult_booth_seq_pkg.sv - shared widths and FSM encodings for the Booth multiplier
package mult_booth_seq_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_booth_seq_booth_step.sv
// rtl/mult_booth_seq_booth_step.sv - one radix-2 Booth iteration: add/sub select plus arithmetic shift
module booth_step
  import mult_booth_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2*WIDTH:0] product,
  input  logic [WIDTH-1:0] mcand,
  output logic [2*WIDTH:0] next_product
);

  logic [WIDTH:0] hi_ext;
  logic [WIDTH:0] mcand_ext;
  logic [WIDTH:0] sum;

  // 33-bit sum keeps the true sign even when mcand is the most negative value
  always_comb begin
    hi_ext    = {product[2*WIDTH], product[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand[WIDTH-1], mcand};
    case (product[1:0])
      2'b01:   sum = hi_ext + mcand_ext;
      2'b10:   sum = hi_ext - mcand_ext;
      default: sum = hi_ext;
    endcase
    next_product = {sum, product[WIDTH:1]};
  end

endmodule

// File: rtl/mult_booth_seq.sv
// rtl/mult_booth_seq.sv - sequential signed radix-2 Booth multiplier, one iteration per clock
module mult_booth_seq
  import mult_booth_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [2*WIDTH:0]   product,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   step_product;
  logic               last_iter;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .product      (product),
    .mcand        (mcand),
    .next_product (step_product)
  );

  assign last_iter = (state_q == RUN) && (count == LAST_CNT);

  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (count == LAST_CNT) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // A start edge wins over everything, so a restart in RUN suppresses the old RDY
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count          <= '0;
      mcand          <= '0;
      product        <= '0;
      data_resultRDY <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_resultRDY <= last_iter && !ctrl_MULT;
      if (ctrl_MULT) begin
        mcand   <= data_operandA;
        product <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        count   <= '0;
      end else if (state_q == RUN) begin
        product <= step_product;
        count   <= (count == SAT_CNT) ? count : count + 1'b1;
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign data_result = product[WIDTH:1];

endmodule

// File: tb/tb_mult_booth_seq.sv
// tb/tb_mult_booth_seq.sv - directed self-checking bench for mult_booth_seq
module tb_mult_booth_seq;
  logic        clk;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [64:0] product;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int compared;
  int mismatched;

  mult_booth_seq dut (
    .clock          (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .product        (product),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the following posedge is the start edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clk);
    ctrl_MULT     = 1'b0;
  endtask

  // Watches n cycles after E0, scrambling operands to show they are ignored.
  task automatic run_window(input int n, output int first, output int pulses,
                            output logic [64:0] prod_at, output logic [31:0] res_at,
                            output logic busy_at);
    first = -1; pulses = 0; prod_at = '0; res_at = '0; busy_at = 1'b1;
    for (int i = 1; i <= n; i++) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      @(negedge clk);
      if (data_resultRDY) begin
        pulses++;
        if (first < 0) begin
          first   = i;
          prod_at = product;
          res_at  = data_result;
          busy_at = busy;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    #1;
    compared++;
    if (product !== 65'd0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: product=%h rdy=%b busy=%b required 0/0/0", product, data_resultRDY, busy);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
    int first, pulses; logic [64:0] p; logic [31:0] r; logic bz;
    start_op(a, b);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("FAIL %s_busy_start: busy=%b required 1", name, busy);
    end
    run_window(40, first, pulses, p, r, bz);
    compared++;
    if (first !== 32 || pulses !== 1) begin
      mismatched++; $display("FAIL %s_rdy_timing: first=%0d pulses=%0d required 32/1", name, first, pulses);
    end
    compared++;
    if (p[64:1] !== exp) begin
      mismatched++; $display("FAIL %s_product: %h required %h", name, p[64:1], exp);
    end
    compared++;
    if (r !== exp[31:0]) begin
      mismatched++; $display("FAIL %s_data_result: %h required %h", name, r, exp[31:0]);
    end
    compared++;
    if (bz !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL %s_busy_done: busy_at_rdy=%b busy_now=%b required 0/0", name, bz, busy);
    end
    compared++;
    if (product[64:1] !== exp) begin
      mismatched++; $display("FAIL %s_hold: %h required %h", name, product[64:1], exp);
    end
  endtask

  task automatic test_basic();
    check_mult("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    check_mult("m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
  endtask

  task automatic test_boundaries();
    check_mult("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    check_mult("big", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    check_mult("m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000);
  endtask

  task automatic test_restart();
    int first, pulses; logic [64:0] p; logic [31:0] r; logic bz;
    start_op(32'd3, 32'd5);
    run_window(9, first, pulses, p, r, bz);
    start_op(32'd2, 32'd2);
    run_window(40, first, pulses, p, r, bz);
    compared++;
    if (first !== 32 || pulses !== 1) begin
      mismatched++; $display("FAIL restart_rdy_timing: first=%0d pulses=%0d required 32/1", first, pulses);
    end
    compared++;
    if (r !== 32'd4) begin
      mismatched++; $display("FAIL restart_data_result: %h required 00000004", r);
    end
  endtask

  task automatic test_reset_mid();
    int first, pulses; logic [64:0] p; logic [31:0] r; logic bz;
    start_op(32'd3, 32'd5);
    run_window(14, first, pulses, p, r, bz);
    reset = 1'b1;
    #1;
    compared++;
    if (product !== 65'd0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: product=%h rdy=%b busy=%b required 0/0/0", product, data_resultRDY, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    run_window(40, first, pulses, p, r, bz);
    compared++;
    if (pulses !== 0) begin
      mismatched++; $display("FAIL reset_mid_no_rdy: pulses=%0d required 0", pulses);
    end
    check_mult("after_reset", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
  endtask

  task automatic test_back_to_back();
    int first, pulses; logic [64:0] p; logic [31:0] r; logic bz;
    start_op(32'd3, 32'd5);
    run_window(31, first, pulses, p, r, bz);
    compared++;
    if (pulses !== 0) begin
      mismatched++; $display("FAIL b2b_early_rdy: pulses=%0d required 0", pulses);
    end
    @(negedge clk);
    compared++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd15) begin
      mismatched++;
      $display("FAIL b2b_first_rdy: rdy=%b data_result=%h required 1/0000000f", data_resultRDY, data_result);
    end
    start_op(32'hFFFF_FFF9, 32'd6);
    compared++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
      mismatched++; $display("FAIL b2b_restart: rdy=%b busy=%b required 0/1", data_resultRDY, busy);
    end
    run_window(40, first, pulses, p, r, bz);
    compared++;
    if (first !== 32 || pulses !== 1 || r !== 32'hFFFF_FFD6) begin
      mismatched++;
      $display("FAIL b2b_second: first=%0d pulses=%0d data_result=%h required 32/1/ffffffd6", first, pulses, r);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
